// File: rtl/add16_seq.sv
// add16_seq: multi-cycle W-bit adder/subtractor built around one shared 4-bit
// ripple-carry adder. It handles one nibble per clock, from LSB to MSB, and
// keeps the carry in a register between steps.
//
// Handshake (valid/ready style): the block is ready whenever it is not busy,
// which means in IDLE or DONE. A request is accepted at the rising edge where
// start=1 and the block is ready. The operands, ci and sub are captured at
// that edge only. start is ignored while busy. done is a one-cycle pulse in
// the cycle after the last nibble step. s/co/ovf stay valid from that cycle
// until the next result is published.

// 4-bit ripple-carry adder: the only adder in the datapath.
module add4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [4:0] c;

    // Explicit ripple of four full adders.
    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < 4; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
        end
        c_o = c[4];
    end

endmodule

module add16_seq #(
    parameter  int W  = 16,
    localparam int N  = W / 4,
    localparam int KW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ovf,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_d;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          c_q;
    logic [W-1:0]  t_q;
    logic [W-1:0]  t_d;
    logic [W-1:0]  s_q;
    logic          co_q;
    logic          ovf_q;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_s;
    logic          nib_co;
    logic          last_step;
    logic          ovf_d;

    // Select the operand nibbles for the current step from the index counter.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    add4 u_add4 (
        .a_i (nib_a),
        .b_i (nib_b),
        .c_i (c_q),
        .s_o (nib_s),
        .c_o (nib_co)
    );

    // Partial sum with this step's nibble merged in, and the next index.
    // ovf uses the fresh sign bit, because on the last step that bit has not
    // been registered yet.
    always_comb begin
        t_d = t_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                t_d[4*i +: 4] = nib_s;
            end
        end
        k_d       = k_q + KW'(1);
        last_step = (k_q == KW'(N - 1));
        ovf_d     = (a_q[W-1] == b_q[W-1]) && (nib_s[3] != a_q[W-1]);
    end

    // Control FSM and datapath registers. The results are written only on the
    // step that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            t_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        c_q     <= sub ? 1'b1 : ci;
                        k_q     <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    t_q <= t_d;
                    c_q <= nib_co;
                    if (last_step) begin
                        s_q     <= t_d;
                        co_q    <= nib_co;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_add16_seq.sv
// Testbench for add16_seq. Directed cases and random operations are checked
// against an arithmetic reference model through an expected-result queue.
module tb_add16_seq;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected results, packed as {ovf, co, s}.
  logic [W+1:0] exp_q[$];
  logic [W-1:0] prev_s;

  add16_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .busy      (busy),
    .done      (done),
    .s         (s),
    .co        (co),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic: co is the carry (add) or no-borrow (sub), and
  // ovf means that the exact signed result does not fit in W bits.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mci, input logic msub);
    longint ua, ub, sa, sb, total, sres;
    logic [W-1:0] rs;
    logic rco, rovf;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      total = ua - ub;
      rco   = (ua >= ub);
      sres  = sa - sb;
    end else begin
      total = ua + ub + longint'(mci);
      rco   = (total >= (64'sd1 <<< W));
      sres  = sa + sb + longint'(mci);
    end
    rs   = total[W-1:0];
    rovf = (sres > ((64'sd1 <<< (W-1)) - 1)) || (sres < -(64'sd1 <<< (W-1)));
    return {rovf, rco, rs};
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge: present a request and record the expected result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ici, input logic isub);
    a     = ia;
    b     = ib;
    ci    = ici;
    sub   = isub;
    start = 1'b1;
    exp_q.push_back(model(ia, ib, ici, isub));
  endtask

  // Moves past the accepting edge, scrambles the inputs, and waits (bounded)
  // for done. Then it checks latency, busy length and the result. When poke
  // is set, it pulses start while busy.
  task automatic wait_result(input string tag, input bit poke);
    int lat;
    int busy_n;
    logic [W+1:0] e;
    @(negedge clk);
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      check_eq({tag, "_hold_s"}, s, prev_s);
      a     = W'($urandom);
      b     = W'($urandom);
      ci    = 1'($urandom);
      sub   = 1'($urandom);
      start = (poke && lat == 1);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, done, 1);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_nonempty"}, done, 0);
    end else begin
      e = exp_q.pop_front();
      if (done) begin
        check_eq({tag, "_s"},   s,   e[W-1:0]);
        check_eq({tag, "_co"},  co,  e[W]);
        check_eq({tag, "_ovf"}, ovf, e[W+1]);
        check_eq({tag, "_latency"}, lat, N);
        check_eq({tag, "_busy_cycles"}, busy_n, N);
      end
      prev_s = e[W-1:0];
    end
  endtask

  // Single operation followed by a one-cycle done-pulse check.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ici, input logic isub);
    issue(ia, ib, ici, isub);
    wait_result(tag, 1'b0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d1, d2;
    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;
    ci     = 1'b0;
    prev_s = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_s",    s,    0);
    check_eq("rst_co",   co,   0);
    check_eq("rst_ovf",  ovf,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the arithmetic rules.
    run_op("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0);
    run_op("ripple",     16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("carry_in",   16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1);
    run_op("sub_min",    16'h0000, 16'h8000, 1'b0, 1'b1);

    // start while busy is ignored: nothing follows the done pulse.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_result("poke", 1'b1);
    @(negedge clk);
    check_eq("poke_done_pulse", done, 0);
    check_eq("poke_no_restart", busy, 0);
    repeat (2) @(negedge clk);
    check_eq("poke_still_idle", busy, 0);

    // Back-to-back: start held in the DONE cycle.
    issue(16'h00FF, 16'h0F01, 1'b1, 1'b0);
    wait_result("b2b_first", 1'b0);
    d1 = cyc;
    issue(16'h4000, 16'h4000, 1'b0, 1'b0);
    wait_result("b2b_second", 1'b0);
    d2 = cyc;
    check_eq("b2b_spacing", d2 - d1, N + 1);
    @(negedge clk);
    check_eq("b2b_done_pulse", done, 0);

    // Reset two cycles into RUN.
    issue(16'hABCD, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_s",    s,    0);
    check_eq("arst_co",   co,   0);
    check_eq("arst_ovf",  ovf,  0);
    void'(exp_q.pop_back());
    prev_s = '0;
    begin
      int fired = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (i == 1) rst_n = 1'b1;
        if (done) fired++;
      end
      check_eq("arst_no_done", fired, 0);
    end
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

    // Randomized operations, some chained back-to-back.
    for (int n = 0; n < 40; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      wait_result("rand", 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        check_eq("rand_done_pulse", done, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add16_seq.md
# add16_seq

Multi-cycle W-bit adder/subtractor built around one shared `add4` instance (4-bit ripple-carry adder). It processes one nibble per clock from LSB to MSB and chains the carry through a register between cycles. Wide additions therefore cost one 4-bit adder instead of W/4. It sits between the operand registers and the arithmetic result bus, with a start/busy/done handshake to the issuing controller.

## Interface

Parameters:
- `W`, default 16: operand width. Must be a multiple of 4 and at least 8.
- `N`, derived as W/4 (not overridable): number of nibble steps.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request. Sampled only when the block is not busy.
- `sub`  in  1: operation select. 0 = a+b+ci; 1 = a−b (a + ~b + 1, `ci` ignored).
- `a`  in  W: operand A. Sampled at the accepting edge.
- `b`  in  W: operand B. Sampled at the accepting edge.
- `ci`  in  1: carry in for add. Sampled at the accepting edge.
- `busy`  out  1: high while nibble steps are in progress.
- `done`  out  1: one-cycle pulse; the result is valid.
- `s`  out  W: result. Registered, held until the next result.
- `co`  out  1: carry out of bit W−1. Registered. For `sub`, 1 means no borrow.
- `ovf`  out  1: two's-complement signed overflow. Registered.

## Operation

States:
- IDLE: waiting for `start`.
- RUN: nibble steps in progress.
- DONE: one cycle, result just published.

Transitions:
- IDLE, `start`=1 → RUN. Capture a into a_r, b into b_r (inverted when sub=1), and the carry register c_r = sub ? 1 : ci. Set nibble index k=0.
- RUN, each cycle:
  - Drive `add4` with a_r[4k+3:4k], b_r[4k+3:4k] and c_r.
  - Write the sum nibble into internal sum register t[4k+3:4k] and the adder carry out into c_r.
  - Increment k.
- RUN, on the step where k=N−1 → DONE. At that edge:
  - s ← final t, with the nibble-(N−1) sum merged in.
  - co ← `add4` carry out.
  - ovf ← (a_r[W−1] == b_r[W−1]) && (final s[W−1] != a_r[W−1]).
- DONE, `start`=1 → RUN with a new capture (back-to-back accepted).
- DONE, `start`=0 → IDLE.

Rules:
- `start` in RUN is ignored. No queuing, no error flag.
- `a`, `b`, `ci` and `sub` may change freely after the accepting edge.
- `s`, `co` and `ovf` change only at the edge entering DONE. They are not updated nibble-by-nibble and keep the previous result throughout RUN.
- `busy` = (state == RUN). `done` = (state == DONE).
- The index counter is ceil(log2 N) bits wide. It never wraps inside an operation and is reset to 0 on every accept.

Reset (`rst_n` low, any state, including mid-RUN):
- Immediately state=IDLE and k=0.
- `busy`=0, `done`=0, `s`=0, `co`=0, `ovf`=0.
- a_r, b_r and c_r are cleared.
- An aborted operation never produces `done`.

## Timing

- The accepting edge is E0. Nibble i is computed in the cycle after edge E(i) and registered at E(i+1).
- `done` is high in the cycle following edge EN, so latency is N cycles from the accepting edge (4 for W=16).
- `busy` is high for exactly N cycles.
- Throughput with `start` held high is one result per N+1 cycles.
- The combinational path is one `add4` plus the nibble muxes. There is no W-bit carry chain.

## Test plan

- Add, W=16: a=16'h1234, b=16'h0FFF, ci=0, sub=0 → s=16'h2233, co=0, ovf=0. `done` 4 cycles after the accepting edge and high for exactly 1 cycle. `busy` high for 4 cycles.
- Full carry ripple across nibbles: a=16'hFFFF, b=16'h0001, ci=0 → s=16'h0000, co=1, ovf=0.
- Carry in: a=0, b=0, ci=1 → s=16'h0001, co=0.
- Subtract with borrow: a=16'h0005, b=16'h0007, sub=1, ci=1 (ignored) → s=16'hFFFE, co=0, ovf=0.
- Signed overflow: a=16'h7FFF, b=16'h0001 add → s=16'h8000, ovf=1.
- Signed overflow: a=16'h8000, b=16'h0001, sub=1 → s=16'h7FFF, ovf=1, co=1.
- Handshake and reset:
  - A pulse on `start` while busy is ignored; `s` is unchanged until `done`.
  - `start` held during the DONE cycle starts the next op; the next `done` arrives 5 cycles after the previous one.
  - Asserting `rst_n`=0 two cycles into RUN clears all outputs at once, and `done` never fires.
  - After release, a fresh add of 16'h0001 + 16'h0001 returns 16'h0002.
